// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier.
// One add-and-shift step per clock; W-cycle latency, one-cycle done pulse.
module seq_multiplier #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] P,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [W-1:0]   m;
    logic [W-1:0]   m_n;
    logic [W-1:0]   q;
    logic [W-1:0]   q_n;
    logic [W:0]     acc;
    logic [W:0]     acc_n;
    logic [W:0]     sum;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_n;
    logic [2*W-1:0] p_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            state <= state_n;
            m     <= m_n;
            q     <= q_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            P     <= p_n;
        end
    end

    always_comb begin
        state_n = state;
        m_n     = m;
        q_n     = q;
        acc_n   = acc;
        cnt_n   = cnt;
        p_n     = P;
        // Upper partial product never exceeds 2^W - 1, so W+1 bits hold the carry
        sum     = acc + (q[0] ? {1'b0, m} : '0);
        unique case (state)
            IDLE, DONE: begin
                if (go) begin
                    m_n     = A;
                    q_n     = B;
                    acc_n   = '0;
                    cnt_n   = CW'(W);
                    state_n = CALC;
                end else begin
                    state_n = IDLE;
                end
            end
            CALC: begin
                acc_n = {1'b0, sum[W:1]};
                q_n   = {sum[0], q[W-1:1]};
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    p_n     = {acc_n[W-1:0], q_n};
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: W=4 and W=8 instances, scoreboard of expected
// products pushed at issue and popped on each done pulse.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        go4;
    logic        go8;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [7:0]  p4;
    logic [15:0] p8;
    logic        busy4;
    logic        done4;
    logic        busy8;
    logic        done8;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    seq_multiplier #(.W(4)) u4 (
        .clk(clk), .rst(rst), .go(go4), .A(a4), .B(b4),
        .P(p4), .busy(busy4), .done(done4)
    );

    seq_multiplier #(.W(8)) u8 (
        .clk(clk), .rst(rst), .go(go8), .A(a8), .B(b8),
        .P(p8), .busy(busy8), .done(done8)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic get_done(int w);
        return (w == 4) ? done4 : done8;
    endfunction

    function automatic logic get_busy(int w);
        return (w == 4) ? busy4 : busy8;
    endfunction

    function automatic logic [15:0] get_p(int w);
        return (w == 4) ? {8'b0, p4} : p8;
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Returns at the negedge after the accepting edge (first CALC cycle)
    task automatic start(int w, logic [7:0] a, logic [7:0] b, bit push);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        @(negedge clk);
        if (w == 4) begin
            go4 = 1'b1;
            a4  = a[3:0];
            b4  = b[3:0];
        end else begin
            go8 = 1'b1;
            a8  = a;
            b8  = b;
        end
        if (push) sb.push_back(prod);
        @(negedge clk);
        go4 = 1'b0;
        go8 = 1'b0;
    endtask

    // n0 = edges already elapsed since the go edge; returns in the DONE cycle
    task automatic wait_done(int w, int n0, string tag);
        int n;
        int bc;
        logic [15:0] exp;
        n  = n0;
        bc = n0;
        while (!get_done(w) && n < 40) begin
            bc += int'(get_busy(w));
            @(negedge clk);
            n++;
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
        chk({tag, " latency"}, 16'(n), 16'(w));
        chk({tag, " busy_cycles"}, 16'(bc), 16'(w));
        chk({tag, " busy_in_done"}, 16'(get_busy(w)), 16'd0);
        chk({tag, " product"}, get_p(w), exp);
    endtask

    task automatic after_done(int w, string tag, logic [15:0] exp);
        @(negedge clk);
        chk({tag, " done_pulse"}, 16'(get_done(w)), 16'd0);
        chk({tag, " idle"}, 16'(get_busy(w)), 16'd0);
        chk({tag, " p_hold"}, get_p(w), exp);
    endtask

    initial begin
        rst = 1'b0;
        go4 = 1'b0;
        go8 = 1'b0;
        a4  = '0;
        b4  = '0;
        a8  = '0;
        b8  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("reset P", 16'(p4), 16'd0);
        chk("reset done", 16'(done4), 16'd0);
        chk("reset busy", 16'(busy4), 16'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle P", 16'(p4), 16'd0);
            chk("idle flags", 16'({busy4, done4}), 16'd0);
        end

        start(4, 8'd13, 8'd11, 1'b1);
        wait_done(4, 0, "13x11");
        after_done(4, "13x11", 16'd143);
        repeat (3) @(negedge clk);
        chk("13x11 held", 16'(p4), 16'd143);

        start(4, 8'd15, 8'd15, 1'b1);
        chk("p_hold in calc", 16'(p4), 16'd143);
        wait_done(4, 0, "15x15");
        after_done(4, "15x15", 16'd225);

        start(4, 8'd0, 8'd9, 1'b1);
        wait_done(4, 0, "0x9");
        after_done(4, "0x9", 16'd0);

        // go during CALC must not disturb the operation in flight
        start(4, 8'd3, 8'd5, 1'b1);
        @(negedge clk);
        go4 = 1'b1;
        a4  = 4'd7;
        b4  = 4'd7;
        @(negedge clk);
        go4 = 1'b0;
        wait_done(4, 2, "ignored_go");
        after_done(4, "ignored_go", 16'd15);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ignored_go no_redone", 16'(done4), 16'd0);
        end

        // back-to-back: go held through the DONE cycle
        start(4, 8'd6, 8'd7, 1'b1);
        wait_done(4, 0, "b2b_first");
        go4 = 1'b1;
        a4  = 4'd9;
        b4  = 4'd9;
        sb.push_back(16'd81);
        @(negedge clk);
        go4 = 1'b0;
        chk("b2b reissue busy", 16'(busy4), 16'd1);
        chk("b2b reissue done", 16'(done4), 16'd0);
        chk("b2b p_hold", 16'(p4), 16'd42);
        wait_done(4, 0, "b2b_second");
        after_done(4, "b2b_second", 16'd81);

        // reset in the 2nd CALC cycle aborts the operation
        start(4, 8'd12, 8'd12, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort P", 16'(p4), 16'd0);
        chk("abort done", 16'(done4), 16'd0);
        chk("abort busy", 16'(busy4), 16'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort quiet", 16'({busy4, done4}), 16'd0);
        end
        start(4, 8'd2, 8'd3, 1'b1);
        wait_done(4, 0, "after_abort");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start(4, 8'(a), 8'(b), 1'b1);
                wait_done(4, 0, "sweep4");
            end
        end

        start(8, 8'd255, 8'd255, 1'b1);
        wait_done(8, 0, "w8 max");
        start(8, 8'd0, 8'd200, 1'b1);
        wait_done(8, 0, "w8 zero");
        for (int i = 0; i < 40; i++) begin
            start(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
            wait_done(8, 0, "w8 rand");
        end
        after_done(8, "w8 last", p8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
